icache: RTL

Direct-mapped, read-only instruction cache between the fetch stage and the instruction-side physical memory port. It answers each fetch request with a full 128-bit line. A hit responds in the same cycle; a miss fills the line from memory through a single-outstanding read handshake, then responds. The fetch stage selects the 16-bit instruction from the line itself.

---
 rtl/icache_pkg.sv | 15 +
 rtl/icache_array.sv | 50 +++++
 rtl/icache.sv | 120 ++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared lc3b types plus the instruction-cache constants and state encoding.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_data;

   localparam int ICACHE_OFFSET_BITS  = 4;
   localparam int ICACHE_DEFAULT_SETS = 8;

   typedef enum logic {
      ICACHE_IDLE,
      ICACHE_FILL
   } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped icache.
// Async read port; synchronous write; invalidate beats a same-edge valid write.
module icache_array
   import lc3b_types::*;
#(
   parameter int NUM_SETS = ICACHE_DEFAULT_SETS,
   parameter int IDX      = $clog2(NUM_SETS),
   parameter int TAG_W    = 16 - ICACHE_OFFSET_BITS - IDX
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             invalidate,
   input  logic [IDX-1:0]   rd_index,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output logic [127:0]     rd_data,
   input  logic [IDX-1:0]   wr_index,
   input  logic             wr_valid,
   input  logic             wr_data_en,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [127:0]     wr_data
);

   logic [NUM_SETS-1:0] valid_q;
   logic [TAG_W-1:0]    tag_q  [NUM_SETS];
   lc3b_data            data_q [NUM_SETS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (invalidate) begin
         valid_q <= '0;
      end else if (wr_valid) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   // Tag and data carry no reset; valid alone qualifies them.
   always_ff @(posedge clk) begin
      if (wr_data_en) begin
         tag_q[wr_index]  <= wr_tag;
         data_q[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one outstanding line fill.
// ICACHE_PERF_EN builds the hit/miss counters; otherwise they read 0.
module icache
   import lc3b_types::*;
#(
   parameter int NUM_SETS = ICACHE_DEFAULT_SETS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [15:0]  imem_address,
   input  logic         imem_action_stb,
   input  logic         imem_action_cyc,
   output logic [127:0] imem_rdata,
   output logic         imem_resp,
   input  logic         invalidate,
   output logic [15:0]  pmem_address,
   output logic         pmem_read,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp,
   output logic [31:0]  hit_count,
   output logic [31:0]  miss_count
);

   localparam int IDX   = $clog2(NUM_SETS);
   localparam int OFS   = ICACHE_OFFSET_BITS;
   localparam int TAG_W = 16 - OFS - IDX;

   icache_state_t    state, state_next;
   lc3b_word         miss_addr;
   logic             req, hit, miss_go, fill_we;
   logic             rd_valid;
   logic [TAG_W-1:0] rd_tag;
   logic [IDX-1:0]   req_index;
   logic [TAG_W-1:0] req_tag;
   logic [7:0]       unused_bits;

   assign req       = imem_action_stb & imem_action_cyc;
   assign req_index = imem_address[OFS+IDX-1:OFS];
   assign req_tag   = imem_address[15:OFS+IDX];
   assign unused_bits = {imem_address[3:0], miss_addr[3:0]};

   icache_array #(
      .NUM_SETS (NUM_SETS),
      .IDX      (IDX),
      .TAG_W    (TAG_W)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .invalidate (invalidate),
      .rd_index   (req_index),
      .rd_valid   (rd_valid),
      .rd_tag     (rd_tag),
      .rd_data    (imem_rdata),
      .wr_index   (miss_addr[OFS+IDX-1:OFS]),
      .wr_valid   (fill_we),
      .wr_data_en (fill_we),
      .wr_tag     (miss_addr[15:OFS+IDX]),
      .wr_data    (pmem_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ICACHE_IDLE;
         miss_addr <= '0;
      end else begin
         state <= state_next;
         if (miss_go) miss_addr <= imem_address;
      end
   end

   always_comb begin
      state_next   = state;
      hit          = 1'b0;
      miss_go      = 1'b0;
      fill_we      = 1'b0;
      imem_resp    = 1'b0;
      pmem_read    = 1'b0;
      pmem_address = '0;
      unique case (state)
         ICACHE_IDLE: begin
            hit       = req && rd_valid && (rd_tag == req_tag);
            imem_resp = hit;
            if (req && !hit) begin
               miss_go    = 1'b1;
               state_next = ICACHE_FILL;
            end
         end
         ICACHE_FILL: begin
            pmem_read    = 1'b1;
            pmem_address = {miss_addr[15:4], 4'h0};
            if (pmem_resp) begin
               fill_we    = 1'b1;
               state_next = ICACHE_IDLE;
            end
         end
         default: state_next = ICACHE_IDLE;
      endcase
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_q, miss_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         if (hit)     hit_q  <= hit_q + 32'd1;
         if (miss_go) miss_q <= miss_q + 32'd1;
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule
